// File: rtl/ram_arb_pkg.sv
// Purpose : shared opcodes, FSM state encoding and RAM geometry for the RAM command arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package ram_arb_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 8;

  // RAM command opcodes, carried in ram_din[9:8]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WAIT_RD = 3'd3,
    RESP    = 3'd4
  } state_e;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_arbiter.sv
// Purpose : picks one requester among req_valid; fixed priority (index 0 wins) by default,
//           round-robin starting at ptr when ARB_ROUND_ROBIN_EN is defined.
// Latency : combinational. Backpressure: grant is forced to zero while enable is low.
// Ports   : req_valid/enable/ptr in; grant (one-hot or zero) and grant_idx out.
module req_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               enable,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic          found;
  logic [IW-1:0] cand;

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority has no rotating start point.
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      // ptr holds the requester with the highest priority this round
      cand = IW'((int'(ptr) + k) % NUM_REQ);
`else
      cand = IW'(k);
`endif
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = '0;
    if (enable && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Purpose : shares a single-port 256x8 command RAM between NUM_REQ requesters, expanding each
//           accepted write/read into the RAM's two-command sequence on ram_din/ram_rx_valid.
// Latency : accept->rsp_valid is 3 cycles for a write, 4 for a read (up to TIMEOUT_CYC+3 on timeout).
// Backpressure: one transaction at a time; req_valid is only sampled in IDLE, req_ready pulses on accept.
// Ports   : clk, rst_n (sync, active-low); req_valid/req_we/req_addr/req_wdata in, req_ready out;
//           rsp_valid/rsp_rdata/rsp_err/busy out; ram_din/ram_rx_valid out, ram_dout/ram_tx_valid in.
// Config  : define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*RAM_AW-1:0] req_addr,
  input  logic [NUM_REQ*RAM_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [RAM_DW-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [9:0]                ram_din,
  output logic                      ram_rx_valid,
  input  logic [RAM_DW-1:0]         ram_dout,
  input  logic                      ram_tx_valid
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [IW-1:0]       gidx_q;
  logic                we_q;
  logic [RAM_AW-1:0]   addr_q;
  logic [RAM_DW-1:0]   wdata_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       ptr;
  logic                gnt_vld;
  logic                cnt_done;

  // rst_n gates the enable so nothing is accepted while reset is held
  req_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_valid (req_valid),
    .enable    ((state_q == IDLE) && rst_n),
    .ptr       (ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign gnt_vld   = |gnt;
  assign busy      = (state_q != IDLE);
  assign cnt_done  = (cnt_q == CW'(TIMEOUT_CYC - 1));

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;
  assign ptr = ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ram_rx_valid = 1'b0;
    ram_din      = '0;
    rsp_valid    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) state_d = ADDR;
      end
      ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {we_q ? CMD_WR_ADDR : CMD_RD_ADDR, addr_q};
        state_d      = DATA;
      end
      DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = {we_q ? CMD_WR_DATA : CMD_RD_DATA, we_q ? wdata_q : 8'h00};
        state_d      = we_q ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (ram_tx_valid || cnt_done) state_d = RESP;
      end
      RESP: begin
        rsp_valid[gidx_q] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch and response registers; rsp_rdata/rsp_err only change on the way into RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gidx_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (gnt_vld) begin
        gidx_q  <= gnt_idx;
        we_q    <= req_we[gnt_idx];
        addr_q  <= RAM_AW'(req_addr >> (RAM_AW * int'(gnt_idx)));
        wdata_q <= RAM_DW'(req_wdata >> (RAM_DW * int'(gnt_idx)));
      end
      case (state_q)
        DATA: begin
          cnt_q <= '0;
          if (we_q) rsp_err <= 1'b0;
        end
        WAIT_RD: begin
          if (ram_tx_valid) begin
            rsp_rdata <= ram_dout;
            rsp_err   <= 1'b0;
          end else if (cnt_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Purpose : self-checking bench for ram_cmd_arbiter with a RAM model and a transaction-level reference.
// Latency : n/a. Backpressure: requesters hold req_valid until accepted.
module tb_ram_cmd_arbiter;

  localparam int N   = 2;
  localparam int TO  = 16;
  localparam int AWT = 8 * N;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_we = '0;
  logic [AWT-1:0] req_addr = '0;
  logic [AWT-1:0] req_wdata = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_rdata;
  logic           rsp_err;
  logic           busy;
  logic [9:0]     ram_din;
  logic           ram_rx_valid;
  logic [7:0]     ram_dout = '0;
  logic           ram_tx_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  ram_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [7:0] ram_mem [256];
  logic [7:0] ram_a = '0;
  bit         mute  = 1'b0;
  bit         stray = 1'b0;

  initial begin
    foreach (ram_mem[i]) ram_mem[i] = 8'h00;
    forever begin
      logic       cv;
      logic [9:0] cd;
      @(negedge clk);
      cv = ram_rx_valid;
      cd = ram_din;
      @(posedge clk);
      #1;
      ram_tx_valid = 1'b0;
      if (stray) begin
        ram_tx_valid = 1'b1;
        ram_dout     = 8'h5A;
        stray        = 1'b0;
      end
      if (cv) begin
        case (cd[9:8])
          2'b00: ram_a = cd[7:0];
          2'b01: ram_mem[ram_a] = cd[7:0];
          2'b10: ram_a = cd[7:0];
          default: if (!mute) begin
            ram_tx_valid = 1'b1;
            ram_dout     = ram_mem[ram_a];
          end
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  bit         m_busy = 1'b0, m_resp = 1'b0, m_we = 1'b0, m_err = 1'b0;
  int         m_req = 0, m_k = 0, m_ptr = 0;
  logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [N-1:0] m_acc = '0;

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int j = 0; j < N; j++) begin
      int c;
      c = RR_MODE ? (start + j) % N : j;
      if (((v >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [N-1:0] e_ready, e_rsp;
    logic         e_rx, e_busy;
    logic [9:0]   e_din;
    int           w;
    e_ready = '0; e_rsp = '0; e_rx = 1'b0; e_busy = 1'b0; e_din = '0; w = -1;
    m_acc = '0;
    if (!rst_n) begin
      // a write whose data command already went out still lands in the RAM
      if (m_busy && m_we && m_k == 2 && !m_resp) ref_mem[m_addr] = m_wdata;
      m_busy = 0; m_resp = 0; m_ptr = 0; m_rdata = '0; m_err = 0; m_k = 0;
    end else begin
      if (!m_busy) begin
        w = pick(req_valid, m_ptr);
        if (w >= 0) e_ready = N'(1) << w;
      end else begin
        e_busy = 1'b1;
        if (m_resp) e_rsp = N'(1) << m_req;
        else if (m_k == 1) begin
          e_rx = 1'b1; e_din = {m_we ? 2'b00 : 2'b10, m_addr};
        end else if (m_k == 2) begin
          e_rx = 1'b1; e_din = {m_we ? 2'b01 : 2'b11, m_we ? m_wdata : 8'h00};
        end
      end
      chk("cmp_req_ready", req_ready, e_ready);
      chk("cmp_rsp_valid", rsp_valid, e_rsp);
      chk("cmp_busy", busy, e_busy);
      chk("cmp_rx_valid", ram_rx_valid, e_rx);
      chk("cmp_din", ram_din, e_din);
      chk("cmp_rdata", rsp_rdata, m_rdata);
      chk("cmp_err", rsp_err, m_err);
      if (!m_busy) begin
        if (w >= 0) begin
          m_acc   = e_ready;
          m_busy  = 1; m_req = w; m_k = 1; m_resp = 0;
          m_we    = ((req_we >> w) & 1) != 0;
          m_addr  = 8'(req_addr >> (8 * w));
          m_wdata = 8'(req_wdata >> (8 * w));
          m_ptr   = (w + 1) % N;
        end
      end else if (m_resp) begin
        m_busy = 0; m_resp = 0;
      end else if (m_k == 1) begin
        m_k = 2;
      end else if (m_k == 2) begin
        if (m_we) begin
          ref_mem[m_addr] = m_wdata; m_err = 0; m_resp = 1;
        end else m_k = 3;
      end else begin
        if (ram_tx_valid) begin
          m_rdata = ref_mem[m_addr]; m_err = 0; m_resp = 1;
        end else if (m_k - 3 == TO - 1) begin
          m_rdata = 8'h00; m_err = 1; m_resp = 1;
        end else m_k++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    logic [N-1:0]   m;
    logic [AWT-1:0] m8;
    m  = N'(1) << i;
    m8 = AWT'(8'hFF) << (8 * i);
    req_valid = req_valid | m;
    req_we    = we ? (req_we | m) : (req_we & ~m);
    req_addr  = (req_addr & ~m8) | (AWT'(a) << (8 * i));
    req_wdata = (req_wdata & ~m8) | (AWT'(d) << (8 * i));
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, busy, ram_rx_valid, ram_din, rsp_rdata, rsp_err}, '0);
    cyc();
    rst_n = 1'b1;

    // write by req0
    cyc();
    set_req(0, 1'b1, 8'h3C, 8'hA5);
    @(negedge clk); chk("wr_ready", req_ready, 2'b01);
    cyc(); req_valid = '0;
    @(negedge clk); chk("wr_addr_cmd", {ram_rx_valid, ram_din}, {1'b1, 10'h03C});
    cyc();
    @(negedge clk); chk("wr_data_cmd", {ram_rx_valid, ram_din}, {1'b1, 10'h1A5});
    cyc();
    @(negedge clk); chk("wr_rsp", {rsp_valid, rsp_err}, {2'b10 >> 1, 1'b0});
    cyc();

    // read by req1
    set_req(1, 1'b0, 8'h3C, 8'h00);
    @(negedge clk); chk("rd_ready", req_ready, 2'b10);
    cyc(); req_valid = '0;
    @(negedge clk); chk("rd_addr_cmd", ram_din, 10'h23C);
    cyc();
    @(negedge clk); chk("rd_data_cmd", ram_din, 10'h300);
    cyc(); cyc();
    @(negedge clk); chk("rd_rsp", {rsp_valid, rsp_rdata, rsp_err}, {2'b10, 8'hA5, 1'b0});
    cyc();

    // stray tx_valid while idle
    stray = 1'b1;
    cyc();
    @(negedge clk); chk("stray_rsp", {rsp_valid, rsp_rdata}, {2'b00, 8'hA5});
    cyc();
    @(negedge clk); chk("stray_after", {rsp_valid, rsp_rdata}, {2'b00, 8'hA5});

    // read timeout
    cyc();
    mute = 1'b1;
    set_req(0, 1'b0, 8'h10, 8'h00);
    @(negedge clk); chk("to_ready", req_ready, 2'b01);
    for (int t = 1; t < 3 + TO; t++) begin
      cyc();
      if (t == 1) req_valid = '0;
    end
    @(negedge clk); chk("to_pre", rsp_valid, 2'b00);
    cyc();
    @(negedge clk); chk("to_rsp", {rsp_valid, rsp_rdata, rsp_err}, {2'b01, 8'h00, 1'b1});
    mute = 1'b0;
    cyc();
    set_req(1, 1'b0, 8'h3C, 8'h00);
    cyc(); req_valid = '0;
    cyc(); cyc(); cyc();
    @(negedge clk); chk("after_to_rsp", {rsp_valid, rsp_rdata, rsp_err}, {2'b10, 8'hA5, 1'b0});
    cyc();

    // both requesters continuously valid
    set_req(0, 1'b1, 8'h20, 8'h11);
    set_req(1, 1'b1, 8'h21, 8'h22);
    for (int n = 0; n < 4; n++) begin
      int g;
      g = RR_MODE ? (n % 2) : 0;
      @(negedge clk); chk("arb_grant", req_ready, N'(1) << g);
      cyc();
      if (n < 3) set_req(g, 1'b1, 8'h20 + 8'(n), 8'h30 + 8'(n));
      else req_valid = req_valid & ~(N'(1) << g);
      cyc(); cyc(); cyc();
    end
    cyc(); req_valid = '0;
    cyc(); cyc(); cyc();

    // reset during the data command of a write, with req1 pending
    set_req(0, 1'b1, 8'h40, 8'h77);
    @(negedge clk); chk("rst_wr_ready", req_ready, 2'b01);
    cyc(); req_valid = '0; set_req(1, 1'b0, 8'h40, 8'h00);
    cyc(); rst_n = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_mid_outputs", {req_ready, rsp_valid, busy, ram_rx_valid, ram_din, rsp_rdata, rsp_err}, '0);
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk("rst_reaccept", req_ready, 2'b10);
    cyc(); req_valid = '0;
    cyc(); cyc(); cyc();
    @(negedge clk); chk("rst_rd_rsp", {rsp_valid, rsp_rdata, rsp_err}, {2'b10, 8'h77, 1'b0});
    cyc();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cyc();
      req_valid = req_valid & ~m_acc;
      for (int i = 0; i < N; i++) begin
        if (((req_valid >> i) & 1) == 0 && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      end
      mute = ($urandom_range(0, 9) == 0);
    end
    cyc(); req_valid = req_valid & ~m_acc;
    repeat (TO + 8) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
Shares the single-port 256x8 command-driven RAM between NUM_REQ requesters, e.g. the SPI slave front end and a debug/host port. Each requester issues a whole transaction: write (addr+data) or read (addr -> data). The block expands each transaction into the RAM's 2-command sequence on the 10-bit din/rx_valid bus and returns read data or a write ack. Transactions are atomic: commands from different requesters never interleave, because the RAM holds address state between commands.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT_CYC, 16, cycles to wait for ram_tx_valid on a read before error completion (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_valid  input  NUM_REQ  per-requester transaction request
req_we  input  NUM_REQ  1=write, 0=read
req_addr  input  NUM_REQ*8  packed addresses, requester i at [8i+7:8i]
req_wdata  input  NUM_REQ*8  packed write data
req_ready  output  NUM_REQ  one-hot accept pulse
rsp_valid  output  NUM_REQ  one-hot completion pulse
rsp_rdata  output  8  read data for the completing requester
rsp_err  output  1  completion is a read timeout, qualified by rsp_valid
busy  output  1  transaction in flight (state != IDLE)
ram_din  output  10  {opcode[1:0], payload[7:0]} to RAM
ram_rx_valid  output  1  command strobe to RAM
ram_dout  input  8  RAM read data
ram_tx_valid  input  1  RAM read-data valid

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer at requester 0, timeout counter 0. Reset in any state aborts the transaction with no rsp_valid, and ram_rx_valid drops in the next cycle.
- Opcodes: WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11.
- FSM states: IDLE, ADDR, DATA, WAIT_RD, RESP.
- IDLE: if any req_valid is set, pick a winner (see arbitration), pulse req_ready[winner] for 1 cycle (combinational in IDLE), and latch grant index, we, addr and wdata. Next state is ADDR. req_valid is sampled only in IDLE. A requester holds req_valid until its req_ready.
- ADDR: ram_rx_valid=1, ram_din={we?00:10, addr}. Next state is DATA.
- DATA: ram_rx_valid=1, ram_din={we?01:11, we?wdata:8'h00}. Next state is RESP for a write, WAIT_RD for a read (timeout counter cleared).
- WAIT_RD: ram_rx_valid=0. When ram_tx_valid=1, capture ram_dout into rsp_rdata, set rsp_err=0, go to RESP. Otherwise increment the counter. When the counter reaches TIMEOUT_CYC-1 with no tx_valid, set rsp_rdata=0, rsp_err=1, go to RESP.
- RESP: rsp_valid[grant]=1 for exactly 1 cycle, then IDLE. rsp_rdata and rsp_err hold until the next RESP. A write leaves rsp_rdata unchanged and sets rsp_err=0.
- Latency from accept to rsp_valid: write 3 cycles. Read nominally 4 cycles, because RAM tx_valid is registered 1 cycle after the RD_DATA command.
- ram_rx_valid is 0 in IDLE, WAIT_RD and RESP. ram_din is 0 whenever ram_rx_valid=0.
- Minimum spacing of back-to-back accepts: write 4 cycles, read 5 cycles.
- A stray ram_tx_valid outside WAIT_RD is ignored.
- Only one of req_ready/rsp_valid is ever set at a time. Both are one-hot or zero.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: round-robin arbitration. Search starts at the requester after the last granted one. The pointer updates on each accept.
- Undefined: fixed priority, lowest index wins (requester 0 highest). No pointer state exists.

Decomposition:
- Shared package ram_arb_pkg holds:
  - opcode localparams CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA;
  - the state encoding constants for IDLE/ADDR/DATA/WAIT_RD/RESP;
  - RAM_AW=8 and RAM_DW=8.
- One sub-module, req_arbiter: takes req_valid, enable and the pointer; produces the one-hot grant and the grant index. It implements both the fixed-priority and round-robin variants under the macro.

Test Plan:
- Req0 write addr 8'h3C data 8'hA5 -> req_ready[0] at T0; ram_din 10'h03C at T1 and 10'h1A5 at T2 with rx_valid; rsp_valid[0] at T3 with rsp_err=0.
- Then req1 read addr 8'h3C, RAM model returns tx_valid with 8'hA5 -> ram_din 10'h23C then 10'h300; rsp_valid[1] with rsp_rdata=8'hA5, rsp_err=0.
- Req0 and req1 valid together, both continuously:
  - with ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1;
  - without it, only req0 is granted;
  - in both cases commands never interleave.
- Read with RAM model never asserting tx_valid -> rsp_valid after TIMEOUT_CYC wait cycles, rsp_err=1, rsp_rdata=8'h00; the next transaction proceeds normally.
- rst_n low during DATA of a write -> next cycle all outputs 0, state IDLE, no rsp_valid; a pending request is re-accepted after reset release.
- ram_tx_valid pulsed in IDLE -> no rsp_valid, rsp_rdata unchanged.
